modmul_256: RTL

Sequential 256-bit modular multiplier computing out_data = (opA × opB) mod opM with an in_valid/out_valid handshake. It is the datapath block driven by the modular-multiply pattern bench and used by the ECC point-arithmetic layer. It uses bit-serial interleaved multiplication, MSB of opB first, with fixed latency.

---
 rtl/modmul_256.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/modmul_256.sv
// ---------------------------------------------------------------------------
// modmul_256 -- sequential modular multiplier: out_data = (opA * opB) mod opM
//
// Bit-serial interleaved multiplication, multiplier consumed MSB first.
// Each RUN cycle doubles the accumulator and conditionally adds opA, keeping
// the accumulator reduced below opM after each doubling and each addition.
// Latency is fixed and never depends on the operand values.
//
// Build option:
//   MODMUL_RADIX4_EN  when defined, two interleaved steps are chained per
//                     cycle (latency WIDTH/2, WIDTH must be even). Results
//                     are identical to the default one-step-per-cycle build.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   opA        multiplicand (caller keeps opA < opM)
//   opB        multiplier
//   opM        modulus (opM == 0 yields result 0)
//   in_valid   one-cycle operand strobe, ignored while busy
//   out_data   result, held until the next result completes
//   out_valid  one-cycle pulse when out_data updates
//   busy       high while a multiplication is in progress
// ---------------------------------------------------------------------------
module modmul_256 #(
   parameter int WIDTH = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic [WIDTH-1:0] opM,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             busy
);

`ifdef MODMUL_RADIX4_EN
   localparam int N = WIDTH / 2;
`else
   localparam int N = WIDTH;
`endif
   // multiplier bits consumed per RUN cycle
   localparam int SH = WIDTH / N;
   localparam int CW = $clog2(N);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_lat, b_sh, m_lat;
   logic [WIDTH:0]   acc, acc_step;
   logic [CW-1:0]    cnt;
   logic             start, finish, last_step;

   // One interleaved step: r <- 2r mod m, then r <- (r + a) mod m if bit set.
   // With r < m and a < m every intermediate is below 2m, so WIDTH+1 bits
   // hold it and a single conditional subtraction restores r < m.
   function automatic logic [WIDTH:0] mm_step(input logic [WIDTH:0]   r,
                                              input logic             bit_b,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] m);
      logic [WIDTH:0] t;
      logic [WIDTH:0] mx;
      mx = {1'b0, m};
      t  = r << 1;
      if (t >= mx) t = t - mx;
      if (bit_b) begin
         t = t + {1'b0, a};
         if (t >= mx) t = t - mx;
      end
      return t;
   endfunction

`ifdef MODMUL_RADIX4_EN
   assign acc_step = mm_step(mm_step(acc, b_sh[WIDTH-1], a_lat, m_lat),
                             b_sh[WIDTH-2], a_lat, m_lat);
`else
   assign acc_step = mm_step(acc, b_sh[WIDTH-1], a_lat, m_lat);
`endif

   assign last_step = (cnt == CW'(N - 1));

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // FSM next state and control strobes
   always_comb begin
      state_next = state;
      start      = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               start      = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_step) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_lat     <= '0;
         b_sh      <= '0;
         m_lat     <= '0;
         acc       <= '0;
         cnt       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (start) begin
            a_lat <= opA;
            b_sh  <= opB;
            m_lat <= opM;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
         end else if (state == RUN) begin
            acc  <= acc_step;
            // shifting keeps the bit under test at the top of b_sh
            b_sh <= b_sh << SH;
            cnt  <= cnt + CW'(1);
            if (finish) begin
               // a zero modulus has no meaningful residue; force 0
               out_data  <= (m_lat == '0) ? '0 : acc_step[WIDTH-1:0];
               out_valid <= 1'b1;
               busy      <= 1'b0;
            end
         end
      end
   end

endmodule
